// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state-width helper and elaboration-time KMP transition builder for the serial detector.
package seq_det_pkg;
    localparam int MAX_PAT_LEN = 16;
    localparam int MAX_SW = $clog2(MAX_PAT_LEN + 1);
    typedef logic [MAX_SW-1:0] state_vec_t;

    function automatic int state_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Longest suffix of (first k pattern bits, b) that is also a pattern prefix, capped at pat_len.
    // From k == pat_len this is the overlapping continuation via the failure length.
    function automatic state_vec_t next_state(input int k, input logic b,
                                              input logic [MAX_PAT_LEN-1:0] pat, input int pat_len);
        int lmax;
        int m;
        logic ok;
        logic sb;
        state_vec_t res;
        lmax = (k < pat_len) ? k + 1 : pat_len;
        res = '0;
        for (int l = lmax; l >= 1; l--) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                m = k + 1 - l + j;
                if (m == k) sb = b;
                else sb = pat[4'(pat_len - 1 - m)];
                if (sb != pat[4'(pat_len - 1 - j)]) ok = 1'b0;
            end
            if (ok && res == '0) res = state_vec_t'(l);
        end
        return res;
    endfunction
endpackage

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: saturating match counter with synchronous clear (clear, then count).
// Built only when SEQ_DET_CNT_EN is defined.
`ifdef SEQ_DET_CNT_EN
module seq_det_sat_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CNT_BITS-1:0] cnt_o,
    output logic                sat_o
);
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? CNT_BITS'(inc_i) : (inc_i && !sat_o) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign cnt_o = cnt_q;
    assign sat_o = &cnt_q;
endmodule
`endif

// File: rtl/param_seq_detector.sv
// param_seq_detector: parametrised Moore serial-pattern detector with KMP fallback and overlap select.
// Define SEQ_DET_CNT_EN to add the saturating match counter (match_cnt, cnt_sat, clr_cnt).
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
`ifdef SEQ_DET_CNT_EN
    ,
    parameter int                 CNT_BITS = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i,
    input  logic                in_valid,
    input  logic                overlap,
`ifdef SEQ_DET_CNT_EN
    output logic [CNT_BITS-1:0] match_cnt,
    output logic                cnt_sat,
    input  logic                clr_cnt,
`endif
    output logic                o
);
    localparam int SW = state_w(PAT_LEN);
    localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

    logic [SW-1:0] nxt_tbl [PAT_LEN+1][2];
    logic [SW-1:0] k_q, k_d, k_nxt;

    for (genvar s = 0; s <= PAT_LEN; s++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            assign nxt_tbl[s][b] = SW'(next_state(s, 1'(b), MAX_PAT_LEN'(PATTERN), PAT_LEN));
        end
    end

    // Non-overlap mode treats the bit after a match as the first bit of a fresh search.
    always_comb begin
        k_nxt = (k_q == FULL && !overlap) ? nxt_tbl[0][i] : nxt_tbl[k_q][i];
        k_d = in_valid ? k_nxt : k_q;
    end

    always_ff @(posedge clk) k_q <= rst ? '0 : k_d;

    assign o = (k_q == FULL);

`ifdef SEQ_DET_CNT_EN
    seq_det_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(clr_cnt),
        .inc_i(in_valid && k_nxt == FULL),
        .cnt_o(match_cnt),
        .sat_o(cnt_sat)
    );
`endif
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: scoreboard bench for the 1101 detector; counter checks when SEQ_DET_CNT_EN is defined.
module tb_param_seq_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i = 1'b0;
    logic in_valid = 1'b0;
    logic overlap = 1'b1;
    logic o;
    always #5 clk = ~clk;

`ifdef SEQ_DET_CNT_EN
    logic       clr_cnt = 1'b0;
    logic       cnt_sat;
    logic [1:0] match_cnt;
    param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_BITS(2)) dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .overlap(overlap),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .clr_cnt(clr_cnt), .o(o)
    );
`else
    param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101)) dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .overlap(overlap), .o(o)
    );
`endif

    typedef struct packed {
        logic       o;
        logic [7:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          pulses = 0;
    logic [15:0] hist = '0;
    int          len = 0;
    logic        pm = 1'b0;
    logic        eo = 1'b0;
    int          cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: shift history of bits since the last restart; match when the last four are 1101.
    task automatic step(input logic b, input logic v, input logic ov,
                        input logic r = 1'b0, input logic c = 1'b0);
        exp_t e;
        @(negedge clk);
        i = b;
        in_valid = v;
        overlap = ov;
        rst = r;
`ifdef SEQ_DET_CNT_EN
        clr_cnt = c;
`endif
        if (r) begin
            hist = '0;
            len = 0;
            pm = 1'b0;
            eo = 1'b0;
            cnt = 0;
        end else if (v) begin
            if (pm && !ov) len = 0;
            hist = {hist[14:0], b};
            if (len < 16) len++;
            eo = (len >= 4) && (hist[3:0] == 4'b1101);
            pm = eo;
            if (c) cnt = eo ? 1 : 0;
            else if (eo && cnt < 3) cnt++;
        end
        e.o = eo;
        e.cnt = 8'(cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("o", 32'(o), 32'(e.o));
        if (o) pulses++;
`ifdef SEQ_DET_CNT_EN
        chk("match_cnt", 32'(match_cnt), 32'(e.cnt));
        chk("cnt_sat", 32'(cnt_sat), 32'(e.cnt == 8'd3));
`endif
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input logic ov);
        for (int j = n - 1; j >= 0; j--) step(bits[4'(j)], 1'b1, ov);
    endtask

    task automatic rst_pulse();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pulses = 0;
    endtask

    initial begin
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        pulses = 0;
        stream(16'b1101, 4, 1'b1);
        chk("first_match", 32'(pulses), 32'd1);

        rst_pulse();
        stream(16'b1101101, 7, 1'b1);
        chk("overlap_pulses", 32'(pulses), 32'd2);

        rst_pulse();
        stream(16'b1101101, 7, 1'b0);
        chk("no_overlap_pulses", 32'(pulses), 32'd1);

        rst_pulse();
        stream(16'b11101, 5, 1'b1);
        chk("fallback_11101", 32'(pulses), 32'd1);

        rst_pulse();
        stream(16'b11001101, 8, 1'b1);
        chk("fallback_11001101", 32'(pulses), 32'd1);

        rst_pulse();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("gap_rise", 32'(o), 32'd1);
        repeat (2) step(1'b0, 1'b0, 1'b1);
        chk("gap_hold", 32'(o), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("gap_fall", 32'(o), 32'd0);

`ifdef SEQ_DET_CNT_EN
        rst_pulse();
        stream(16'b1101101101101101, 16, 1'b1);
        chk("sat_pulses", 32'(pulses), 32'd5);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_with_match", 32'(match_cnt), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_alone", 32'(match_cnt), 32'd0);
`endif

        rst_pulse();
        stream(16'b110, 3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_mid_match", 32'(pulses), 32'd0);

        rst_pulse();
        for (int n = 0; n < 120; n++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
